// File: rtl/lm32_ram_dp.sv
// Simple dual-port RAM: one synchronous write port and one registered read port, single clock.
// Same-address read/write on one edge returns the new data (write-first).
module lm32_ram_dp #(
  parameter int data_width    = 32,
  parameter int address_width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [address_width-1:0] read_address,
  input  logic                     enable_read,
  input  logic [address_width-1:0] write_address,
  input  logic                     enable_write,
  input  logic                     write_enable,
  input  logic [data_width-1:0]    write_data,
  output logic [data_width-1:0]    read_data
);

  localparam int depth = 2 ** address_width;

  logic [data_width-1:0] mem_r [depth];
  logic                  wr_s;
  logic                  bypass_s;

  assign wr_s     = enable_write & write_enable;
  assign bypass_s = wr_s & (read_address == write_address);

  // Storage array; writes deliberately ignore reset so the client can flush while reset is held.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_r[write_address] <= write_data;
    end
  end

  // Registered read port with write-first bypass; holds its value when the read is not enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data <= '0;
    end else if (enable_read) begin
      if (bypass_s) begin
        read_data <= write_data;
      end else begin
        read_data <= mem_r[read_address];
      end
    end
  end

endmodule

// File: tb/tb_lm32_ram_dp.sv
// Self-checking bench for lm32_ram_dp: directed steps followed by random traffic against a reference model.
module tb_lm32_ram_dp;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [7:0]  read_address = 8'h00;
  logic        enable_read = 1'b0;
  logic [7:0]  write_address = 8'h00;
  logic        enable_write = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;

  int compared = 0;
  int mismatched = 0;

  // Reference model: memory contents, which words are defined, and the expected output register.
  logic [31:0] ref_mem [256];
  bit          ref_def [256];
  logic [31:0] exp_q = 32'h0;
  bit          exp_known = 1'b0;

  lm32_ram_dp #(.data_width(32), .address_width(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .read_address(read_address), .enable_read(enable_read),
    .write_address(write_address), .enable_write(enable_write),
    .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: read_data=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, update the model at the rising edge, check 1 time unit later.
  task automatic cyc(input string tag, input bit rst, input bit re, input logic [7:0] ra,
                     input bit ew, input bit we, input logic [7:0] wa, input logic [31:0] wd);
    @(negedge clk_i);
    rst_ni = rst; enable_read = re; read_address = ra;
    enable_write = ew; write_enable = we; write_address = wa; write_data = wd;
    if (!rst) begin
      exp_q = 32'h0; exp_known = 1'b1;
      #1 check({tag, "_async_rst"}, read_data, 32'h0);
    end
    @(posedge clk_i);
    if (!rst) begin
      exp_q = 32'h0; exp_known = 1'b1;
    end else if (re) begin
      if (ew && we && wa == ra) begin
        exp_q = wd; exp_known = 1'b1;
      end else begin
        exp_q = ref_mem[ra]; exp_known = ref_def[ra];
      end
    end
    if (ew && we) begin
      ref_mem[wa] = wd; ref_def[wa] = 1'b1;
    end
    #1;
    if (exp_known) check(tag, read_data, exp_q);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'h0; ref_def[i] = 1'b0;
    end
    // Reset from power-up
    #2 rst_ni = 1'b0;
    #1 check("por_reset", read_data, 32'h0);
    exp_q = 32'h0; exp_known = 1'b1;
    cyc("reset_hold", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    cyc("reset_hold2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);

    // Write then read
    cyc("wr_05", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF);
    cyc("rd_05", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    check("rd_05_const", read_data, 32'hDEADBEEF);

    // Gated writes must not change memory
    cyc("gate_we0", 1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 8'h05, 32'h00001234);
    cyc("gate_rd1", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    check("gate_rd1_const", read_data, 32'hDEADBEEF);
    cyc("gate_ew0", 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'h05, 32'h00001234);
    cyc("gate_rd2", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    check("gate_rd2_const", read_data, 32'hDEADBEEF);

    // Same-address collision is write-first
    cyc("collide", 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5);
    check("collide_const", read_data, 32'hA5A5A5A5);
    cyc("collide_mem", 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);

    // Hold while the held location is overwritten and the address moves
    cyc("hold_rd", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    cyc("hold_1", 1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 8'h05, 32'h0);
    cyc("hold_2", 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 8'h05, 32'h0);
    check("hold_const", read_data, 32'hDEADBEEF);
    cyc("hold_release", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    check("hold_release_const", read_data, 32'h0);

    // Mid-run reset with a write landing during reset
    cyc("pre_rst", 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0);
    cyc("mid_rst", 1'b0, 1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 32'h00000077);
    cyc("post_rst", 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0);
    check("wr_in_rst_const", read_data, 32'h00000077);

    // Sweep: fill every word, then read back-to-back
    for (int i = 0; i < 256; i++)
      cyc("sweep_wr", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'(i), 32'(i) ^ 32'h000055AA);
    for (int i = 0; i < 256; i++)
      cyc("sweep_rd", 1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 32'h0);
    check("sweep_last", read_data, 32'h000055AA ^ 32'h000000FF);

    // Random traffic over a narrow address window to provoke collisions
    for (int i = 0; i < 600; i++) begin
      cyc("random", ($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1,
          8'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          8'($urandom_range(0, 7)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
